// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - shared types and opcode constants for the immediate generator
package imm_pkg;

    // Immediate format code presented on type_o
    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5,
        IMM_Z = 3'd6,
        IMM_X = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - upstream/downstream handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       instr_i;
    logic [TAG_W-1:0]  tag_i;
    logic              valid_o;
    logic              ready_i;
    logic [XLEN-1:0]   imm_o;
    imm_type_e         type_o;
    logic              illegal_o;
    logic [TAG_W-1:0]  tag_o;

    // The generator itself
    modport slave (
        input  valid_i, instr_i, tag_i, ready_i,
        output ready_o, valid_o, imm_o, type_o, illegal_o, tag_o
    );

    // Decode front end / execute consumer side
    modport master (
        output valid_i, instr_i, tag_i, ready_i,
        input  ready_o, valid_o, imm_o, type_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// rtl/imm_gen_pipe_decode.sv - combinational instruction to immediate/format decode
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    output logic [XLEN-1:0]  imm,
    output imm_type_e        typ,
    output logic             illegal
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] sext_i;
    logic [XLEN-1:0] sext_s;
    logic [XLEN-1:0] sext_b;
    logic [XLEN-1:0] sext_u;
    logic [XLEN-1:0] sext_j;
    logic [XLEN-1:0] shamt_x;
    logic [XLEN-1:0] shamt_w;
    logic [XLEN-1:0] zimm;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Signed width casts replicate instr[31] up to bit XLEN-1
    assign sext_i  = XLEN'($signed(instr[31:20]));
    assign sext_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign sext_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign sext_u  = XLEN'($signed({instr[31:12], 12'b0}));
    assign sext_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    // Full-width shifts take a 6-bit shamt on RV64; the *W forms always use 5 bits
    assign shamt_x = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
    assign shamt_w = XLEN'(instr[24:20]);
    assign zimm    = XLEN'(instr[19:15]);

    // Format select from opcode/funct3; unknown or width-illegal opcodes flag X
    always_comb begin
        imm     = '0;
        typ     = IMM_R;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: typ = IMM_R;
            OPC_OP_32: begin
                if (XLEN == 64) begin
                    typ = IMM_R;
                end else begin
                    typ     = IMM_X;
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                typ = IMM_I;
                imm = (funct3[1:0] == 2'b01) ? shamt_x : sext_i;
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    typ = IMM_I;
                    imm = (funct3[1:0] == 2'b01) ? shamt_w : sext_i;
                end else begin
                    typ     = IMM_X;
                    illegal = 1'b1;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                typ = IMM_I;
                imm = sext_i;
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    typ = IMM_Z;
                    imm = zimm;
                end else begin
                    typ = IMM_I;
                    imm = sext_i;
                end
            end
            OPC_STORE: begin
                typ = IMM_S;
                imm = sext_s;
            end
            OPC_BRANCH: begin
                typ = IMM_B;
                imm = sext_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                typ = IMM_U;
                imm = sext_u;
            end
            OPC_JAL: begin
                typ = IMM_J;
                imm = sext_j;
            end
            default: begin
                typ     = IMM_X;
                illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    imm_gen_pipe_if.slave bus
);
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  imm;
        imm_type_e        typ;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } imm_entry_t;

    imm_entry_t out_q, out_d;
    imm_entry_t skid_q, skid_d;
    imm_entry_t in_entry;
    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_typ;
    logic            dec_illegal;
    logic            accept;
    logic            out_free;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.instr_i),
        .imm     (dec_imm),
        .typ     (dec_typ),
        .illegal (dec_illegal)
    );

    // Ready depends only on skid occupancy, so there is no combinational path from ready_i
    assign bus.ready_o = !skid_q.valid;
    assign accept      = bus.valid_i && bus.ready_o;
    assign out_free    = !out_q.valid || bus.ready_i;

    assign in_entry = '{valid: 1'b1, imm: dec_imm, typ: dec_typ,
                        illegal: dec_illegal, tag: bus.tag_i};

    // Buffer steering: skid drains into out first, new words never overtake buffered ones
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (flush_i) begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end else if (out_free) begin
            if (skid_q.valid) begin
                out_d        = skid_q;
                skid_d.valid = 1'b0;
            end else if (accept) begin
                out_d = in_entry;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d = in_entry;
        end
    end

    // Entry registers; reset clears payload so outputs show the reset values
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    assign bus.valid_o   = out_q.valid;
    assign bus.imm_o     = out_q.imm;
    assign bus.type_o    = out_q.typ;
    assign bus.illegal_o = out_q.illegal;
    assign bus.tag_o     = out_q.tag;
endmodule
